// File: rtl/riscie_ctrl_pkg.sv
// Shared definitions for the RV32-subset control path: opcodes, ALU operation
// classes and the main controller state encoding.
package riscie_ctrl_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALU operation classes; the ALU-control block expands ALUOP_R using funct3/funct7.
    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_R_EX,
        ST_R_WB,
        ST_ADDR,
        ST_MEM_RD,
        ST_LD_WB,
        ST_MEM_WR,
        ST_BR_EX,
        ST_HALT
    } ctrl_state_t;

endpackage

// File: rtl/main_control_fsm_if.sv
// Control bundle between the main controller (master) and the datapath/memory
// side (slave).
interface main_control_fsm_if
    import riscie_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic [1:0]       alu_op;
    logic             alu_src;
    logic             reg_write;
    logic             mem_to_reg;
    logic             illegal_instr;
    logic             bus_error;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, alu_src,
               reg_write, mem_to_reg, illegal_instr, bus_error, instret
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, mem_we, ir_write, pc_write, pc_src, alu_op, alu_src,
               reg_write, mem_to_reg, illegal_instr, bus_error, instret
    );

endinterface

// File: rtl/main_control_fsm_mem_wait_timer.sv
// Counts memory wait cycles; expired is high on the last cycle a request may
// still complete before it is declared a timeout.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

    logic [7:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en && !expired) begin
            count_reg <= count_reg + 8'd1;
        end
    end

    assign expired = (count_reg == LAST);

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback,
// waits on the memory handshake, flags illegal opcodes and timeouts, counts retires.
module main_control_fsm
    import riscie_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    main_control_fsm_if.master     bus
);
    ctrl_state_t      state_reg, state_next;
    logic             illegal_reg, illegal_next;
    logic             bus_error_reg, bus_error_next;
    logic [CNT_W-1:0] instret_reg;
    logic             retire;
    logic             in_req;
    logic             wait_clear, wait_en, wait_expired;

    logic       mem_req, mem_we, ir_write, pc_write, pc_src;
    logic [1:0] alu_op;
    logic       alu_src, reg_write, mem_to_reg;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wait_clear),
        .count_en (wait_en),
        .expired  (wait_expired)
    );

    always_comb begin
        state_next     = state_reg;
        illegal_next   = illegal_reg;
        bus_error_next = bus_error_reg;
        retire         = 1'b0;
        in_req         = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src         = 1'b0;
        alu_op         = ALUOP_LDST;
        alu_src        = 1'b0;
        reg_write      = 1'b0;
        mem_to_reg     = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                in_req  = 1'b1;
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_R:         state_next = ST_R_EX;
                    OP_LW, OP_SW: state_next = ST_ADDR;
                    OP_BEQ:       state_next = ST_BR_EX;
                    default: begin
                        state_next   = ST_HALT;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            ST_R_EX: begin
                alu_op     = ALUOP_R;
                state_next = ST_R_WB;
            end
            ST_R_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_ADDR: begin
                alu_src    = 1'b1;
                state_next = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                in_req  = 1'b1;
                mem_req = 1'b1;
                alu_src = 1'b1;
                if (bus.mem_ready) state_next = ST_LD_WB;
            end
            ST_LD_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEM_WR: begin
                in_req  = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                alu_src = 1'b1;
                if (bus.mem_ready) begin
                    retire     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_BR_EX: begin
                alu_op     = ALUOP_BR;
                pc_write   = bus.zero;
                pc_src     = bus.zero;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT:  state_next = ST_HALT;
            default:  state_next = ST_HALT;
        endcase

        // A completing access on the expiry cycle wins over the timeout.
        if (in_req && !bus.mem_ready && wait_expired) begin
            state_next     = ST_HALT;
            bus_error_next = 1'b1;
        end

        // FETCH is the reset state but must not request memory while held in reset.
        if (!rst_n) begin
            mem_req  = 1'b0;
            ir_write = 1'b0;
            pc_write = 1'b0;
        end
    end

    assign wait_clear = !in_req || bus.mem_ready;
    assign wait_en    = in_req && !bus.mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_FETCH;
            illegal_reg   <= 1'b0;
            bus_error_reg <= 1'b0;
            instret_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            illegal_reg   <= illegal_next;
            bus_error_reg <= bus_error_next;
            if (retire) instret_reg <= instret_reg + 1'b1;
        end
    end

    assign bus.mem_req       = mem_req;
    assign bus.mem_we        = mem_we;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_src        = pc_src;
    assign bus.alu_op        = alu_op;
    assign bus.alu_src       = alu_src;
    assign bus.reg_write     = reg_write;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.illegal_instr = illegal_reg;
    assign bus.bus_error     = bus_error_reg;
    assign bus.instret       = instret_reg;

endmodule
